// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the funct3 access encodings, the FSM state encoding and the helper
// that maps an access encoding to its size in bytes.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B   = 3'b000,
    F3_H   = 3'b001,
    F3_W   = 3'b010,
    F3_D   = 3'b011,
    F3_BU  = 3'b100,
    F3_HU  = 3'b101,
    F3_WU  = 3'b110,
    F3_RSV = 3'b111
  } funct3_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Access size in bytes. The reserved encoding reports 8 so the range
  // arithmetic stays well defined; it is faulted separately anyway.
  function automatic logic [3:0] access_size(funct3_t f);
    case (f)
      F3_B, F3_BU: access_size = 4'd1;
      F3_H, F3_HU: access_size = 4'd2;
      F3_W, F3_WU: access_size = 4'd4;
      default:     access_size = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane datapath for the load/store unit.
// Ports:
//   dword      - doubleword captured from memory
//   offset     - byte lane of the access inside the doubleword (addr[2:0])
//   funct3     - access encoding (size and signedness)
//   store_data - right-justified store data
//   load_data  - extracted and sign/zero-extended load result
//   merge_data - dword with the addressed lanes replaced by store_data
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  offset,
  input  funct3_t     funct3,
  input  logic [63:0] store_data,
  output logic [63:0] load_data,
  output logic [63:0] merge_data
);

  logic [5:0]         bit_shift;
  logic [63:0]        shifted;
  logic [63:0]        size_mask;
  logic [63:0]        lane_mask;
  logic signed [63:0] ext_s;

  assign bit_shift = {offset, 3'b000};
  assign shifted   = dword >> bit_shift;

  always_comb begin
    ext_s = '0;
    case (funct3)
      F3_B:    ext_s = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    ext_s = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    ext_s = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    ext_s = shifted;
      F3_BU:   ext_s = {56'd0, shifted[7:0]};
      F3_HU:   ext_s = {48'd0, shifted[15:0]};
      F3_WU:   ext_s = {32'd0, shifted[31:0]};
      default: ext_s = '0;
    endcase
  end

  assign load_data = ext_s;

  always_comb begin
    size_mask = '0;
    case (funct3)
      F3_B, F3_BU: size_mask = 64'h0000_0000_0000_00FF;
      F3_H, F3_HU: size_mask = 64'h0000_0000_0000_FFFF;
      F3_W, F3_WU: size_mask = 64'h0000_0000_FFFF_FFFF;
      default:     size_mask = '1;
    endcase
  end

  // Alignment is checked upstream, so the shifted mask never wraps past lane 7.
  assign lane_mask  = size_mask << bit_shift;
  assign merge_data = (dword & ~lane_mask) | ((store_data << bit_shift) & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from the pipeline, performs
// a doubleword read, a read-modify-write or a direct doubleword write on the
// attached data memory and returns a one-cycle response.
// Ports:
//   clk, reset            - clock (rising edge) and synchronous active-high reset
//   Req_Valid/Req_Ready   - request handshake; ready only while idle
//   Req_Write, Req_Funct3 - store/load select and access size/signedness
//   Req_Addr, Req_Data    - byte address and right-justified store data
//   Resp_Valid            - one-cycle completion pulse
//   Resp_Data             - extended load result (0 for stores)
//   Resp_Misaligned       - address not aligned to the access size
//   Resp_Fault            - out of range or reserved encoding
//   Mem_Addr, Write_Data, MemWrite, MemRead, Read_Data - data memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [2:0]  Req_Funct3,
  input  logic [63:0] Req_Addr,
  input  logic [63:0] Req_Data,
  output logic        Resp_Valid,
  output logic [63:0] Resp_Data,
  output logic        Resp_Misaligned,
  output logic        Resp_Fault,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  state_t      state_p0, state_next;
  funct3_t     req_funct3;
  logic        accept;
  logic        req_fault, req_misal;
  logic [3:0]  req_size;
  logic [64:0] req_end;

  logic        write_p1;
  funct3_t     funct3_p1;
  logic [63:0] addr_p1;
  logic [63:0] data_p1;
  logic        fault_p1;
  logic        misal_p1;
  logic [63:0] rdata_p2;

  logic [63:0] load_data;
  logic [63:0] merge_data;

  assign req_funct3 = funct3_t'(Req_Funct3);
  assign accept     = Req_Valid && (state_p0 == ST_IDLE);

  // Range check in 65 bits so addresses near the top of the space cannot wrap.
  assign req_size  = access_size(req_funct3);
  assign req_end   = {1'b0, Req_Addr} + {61'd0, req_size};
  assign req_fault = (req_funct3 == F3_RSV) || (req_end > 65'(DEPTH_BYTES));

  always_comb begin
    req_misal = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: req_misal = Req_Addr[0];
      F3_W, F3_WU: req_misal = |Req_Addr[1:0];
      F3_D:        req_misal = |Req_Addr[2:0];
      default:     req_misal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_p0 <= ST_IDLE;
    else       state_p0 <= state_next;
  end

  // Request latch and memory capture; data carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p1  <= Req_Write;
      funct3_p1 <= req_funct3;
      addr_p1   <= Req_Addr;
      data_p1   <= Req_Data;
      fault_p1  <= req_fault;
      misal_p1  <= req_misal;
    end
    if ((state_p0 == ST_LOAD) || (state_p0 == ST_RMW_RD)) begin
      rdata_p2 <= Read_Data;
    end
  end

  always_comb begin
    state_next = state_p0;
    case (state_p0)
      ST_IDLE: begin
        if (Req_Valid) begin
          if (req_fault || req_misal) state_next = ST_RESP;
          else if (!Req_Write)        state_next = ST_LOAD;
          else if (req_funct3 == F3_D) state_next = ST_WRITE;
          else                        state_next = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_next = ST_RESP;
      ST_RMW_RD: state_next = ST_WRITE;
      ST_WRITE:  state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  lsu_lane_align u_lane_align (
    .dword      (rdata_p2),
    .offset     (addr_p1[2:0]),
    .funct3     (funct3_p1),
    .store_data (data_p1),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    Req_Ready       = 1'b0;
    Resp_Valid      = 1'b0;
    Resp_Data       = '0;
    Resp_Misaligned = 1'b0;
    Resp_Fault      = 1'b0;
    Mem_Addr        = '0;
    Write_Data      = '0;
    MemWrite        = 1'b0;
    MemRead         = 1'b0;
    case (state_p0)
      ST_IDLE: Req_Ready = 1'b1;
      ST_LOAD, ST_RMW_RD: begin
        Mem_Addr = {addr_p1[63:3], 3'b000};
        MemRead  = 1'b1;
      end
      ST_WRITE: begin
        Mem_Addr   = {addr_p1[63:3], 3'b000};
        MemWrite   = 1'b1;
        Write_Data = (funct3_p1 == F3_D) ? data_p1 : merge_data;
      end
      ST_RESP: begin
        Resp_Valid      = 1'b1;
        Resp_Fault      = fault_p1;
        Resp_Misaligned = misal_p1 && !fault_p1;
        if (!write_p1 && !fault_p1 && !misal_p1) Resp_Data = load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Write;
  logic [2:0]  Req_Funct3;
  logic [63:0] Req_Addr;
  logic [63:0] Req_Data;
  logic        Resp_Valid;
  logic [63:0] Resp_Data;
  logic        Resp_Misaligned;
  logic        Resp_Fault;
  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Read_Data;

  logic [63:0] mem [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
    .Req_Funct3(Req_Funct3), .Req_Addr(Req_Addr), .Req_Data(Req_Data),
    .Resp_Valid(Resp_Valid), .Resp_Data(Resp_Data),
    .Resp_Misaligned(Resp_Misaligned), .Resp_Fault(Resp_Fault),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemWrite(MemWrite),
    .MemRead(MemRead), .Read_Data(Read_Data)
  );

  // Behavioural doubleword memory: asynchronous read, write on falling edge.
  assign Read_Data = mem[Mem_Addr[5:3]];
  always @(negedge clk) begin
    if (MemWrite) mem[Mem_Addr[5:3]] = Write_Data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns at accept+1 with Req_Valid low.
  task automatic issue(input logic w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] d);
    Req_Valid = 1'b1; Req_Write = w; Req_Funct3 = f3; Req_Addr = a; Req_Data = d;
    tick();
    Req_Valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Req_Valid = 1'b1; Req_Write = 1'b0; Req_Funct3 = 3'b000; Req_Addr = 64'd8; Req_Data = '0;
    tick(); tick();
    checks++; if (Req_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", Req_Ready); end
    checks++; if (Resp_Valid !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got rv=%b rd=%b wr=%b want 0", Resp_Valid, MemRead, MemWrite); end
    checks++; if (Mem_Addr !== 64'd0 || Resp_Data !== 64'd0 || Write_Data !== 64'd0) begin errors++; $display("FAIL reset_data: got ma=%h rd=%h wd=%h want 0", Mem_Addr, Resp_Data, Write_Data); end
    Req_Valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_byte();
    issue(1'b0, 3'b000, 64'd15, 64'd0);
    checks++; if (MemRead !== 1'b1 || Mem_Addr !== 64'd8) begin errors++; $display("FAIL lb_read: got rd=%b ma=%h want 1/8", MemRead, Mem_Addr); end
    checks++; if (Req_Ready !== 1'b0 || Resp_Valid !== 1'b0) begin errors++; $display("FAIL lb_busy: got rdy=%b rv=%b want 0/0", Req_Ready, Resp_Valid); end
    tick();
    checks++; if (Resp_Valid !== 1'b1 || Resp_Data !== 64'hFFFF_FFFF_FFFF_FF88) begin errors++; $display("FAIL lb_resp: got rv=%b d=%h want 1/ffffffffffffff88", Resp_Valid, Resp_Data); end
    tick();
    checks++; if (Resp_Valid !== 1'b0 || Resp_Data !== 64'd0 || Req_Ready !== 1'b1) begin errors++; $display("FAIL lb_after: got rv=%b d=%h rdy=%b want 0/0/1", Resp_Valid, Resp_Data, Req_Ready); end
    issue(1'b0, 3'b100, 64'd15, 64'd0);
    tick();
    checks++; if (Resp_Valid !== 1'b1 || Resp_Data !== 64'h88) begin errors++; $display("FAIL lbu_resp: got rv=%b d=%h want 1/88", Resp_Valid, Resp_Data); end
    tick();
  endtask

  task automatic test_store_half();
    issue(1'b1, 3'b001, 64'd10, 64'h1234_5678_9ABC_BEEF);
    checks++; if (MemRead !== 1'b1 || MemWrite !== 1'b0) begin errors++; $display("FAIL sh_rd: got rd=%b wr=%b want 1/0", MemRead, MemWrite); end
    tick();
    checks++; if (MemWrite !== 1'b1 || MemRead !== 1'b0 || Mem_Addr !== 64'd8) begin errors++; $display("FAIL sh_wr: got wr=%b rd=%b ma=%h want 1/0/8", MemWrite, MemRead, Mem_Addr); end
    checks++; if (Write_Data !== 64'h8877_6655_BEEF_2211) begin errors++; $display("FAIL sh_wdata: got %h want 88776655beef2211", Write_Data); end
    tick();
    checks++; if (Resp_Valid !== 1'b1 || Resp_Data !== 64'd0 || MemWrite !== 1'b0) begin errors++; $display("FAIL sh_resp: got rv=%b d=%h wr=%b want 1/0/0", Resp_Valid, Resp_Data, MemWrite); end
    checks++; if (mem[1] !== 64'h8877_6655_BEEF_2211) begin errors++; $display("FAIL sh_mem: got %h want 88776655beef2211", mem[1]); end
    tick();
  endtask

  task automatic test_store_dword();
    int writes = 0;
    issue(1'b1, 3'b011, 64'd16, 64'h0123_4567_89AB_CDEF);
    checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b1 || Mem_Addr !== 64'd16) begin errors++; $display("FAIL sd_wr: got rd=%b wr=%b ma=%h want 0/1/10", MemRead, MemWrite, Mem_Addr); end
    checks++; if (Write_Data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL sd_wdata: got %h want 0123456789abcdef", Write_Data); end
    if (MemWrite) writes++;
    tick();
    if (MemWrite) writes++;
    checks++; if (Resp_Valid !== 1'b1 || MemRead !== 1'b0) begin errors++; $display("FAIL sd_resp: got rv=%b rd=%b want 1/0", Resp_Valid, MemRead); end
    tick();
    if (MemWrite) writes++;
    checks++; if (writes != 1) begin errors++; $display("FAIL sd_single_write: got %0d want 1", writes); end
    issue(1'b0, 3'b011, 64'd16, 64'd0);
    tick();
    checks++; if (Resp_Data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL ld_d: got %h want 0123456789abcdef", Resp_Data); end
    tick();
    issue(1'b0, 3'b001, 64'd10, 64'd0);
    tick();
    checks++; if (Resp_Data !== 64'hFFFF_FFFF_FFFF_BEEF) begin errors++; $display("FAIL ld_h: got %h want ffffffffffffbeef", Resp_Data); end
    tick();
    issue(1'b0, 3'b101, 64'd10, 64'd0);
    tick();
    checks++; if (Resp_Data !== 64'h0000_0000_0000_BEEF) begin errors++; $display("FAIL ld_hu: got %h want beef", Resp_Data); end
    tick();
    issue(1'b0, 3'b010, 64'd12, 64'd0);
    tick();
    checks++; if (Resp_Data !== 64'hFFFF_FFFF_8877_6655) begin errors++; $display("FAIL ld_w: got %h want ffffffff88776655", Resp_Data); end
    tick();
    issue(1'b0, 3'b110, 64'd12, 64'd0);
    tick();
    checks++; if (Resp_Data !== 64'h0000_0000_8877_6655) begin errors++; $display("FAIL ld_wu: got %h want 88776655", Resp_Data); end
    tick();
  endtask

  task automatic test_misaligned_fault();
    issue(1'b0, 3'b010, 64'd6, 64'd0);
    checks++; if (Resp_Valid !== 1'b1 || Resp_Misaligned !== 1'b1 || Resp_Fault !== 1'b0) begin errors++; $display("FAIL lw_mis: got rv=%b mis=%b flt=%b want 1/1/0", Resp_Valid, Resp_Misaligned, Resp_Fault); end
    checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b0 || Resp_Data !== 64'd0) begin errors++; $display("FAIL lw_mis_mem: got rd=%b wr=%b d=%h want 0/0/0", MemRead, MemWrite, Resp_Data); end
    tick();
    checks++; if (Resp_Misaligned !== 1'b0 || Req_Ready !== 1'b1) begin errors++; $display("FAIL lw_mis_clear: got mis=%b rdy=%b want 0/1", Resp_Misaligned, Req_Ready); end
    issue(1'b0, 3'b101, 64'd11, 64'd0);
    checks++; if (Resp_Misaligned !== 1'b1 || MemRead !== 1'b0) begin errors++; $display("FAIL lhu_mis: got mis=%b rd=%b want 1/0", Resp_Misaligned, MemRead); end
    tick();
    issue(1'b0, 3'b011, 64'd60, 64'd0);
    checks++; if (Resp_Valid !== 1'b1 || Resp_Fault !== 1'b1 || Resp_Misaligned !== 1'b0) begin errors++; $display("FAIL ld_fault: got rv=%b flt=%b mis=%b want 1/1/0", Resp_Valid, Resp_Fault, Resp_Misaligned); end
    tick();
    issue(1'b1, 3'b111, 64'd0, 64'd5);
    checks++; if (Resp_Fault !== 1'b1 || MemWrite !== 1'b0) begin errors++; $display("FAIL rsv_fault: got flt=%b wr=%b want 1/0", Resp_Fault, MemWrite); end
    tick();
    issue(1'b1, 3'b000, 64'd64, 64'd5);
    checks++; if (Resp_Fault !== 1'b1 || MemRead !== 1'b0) begin errors++; $display("FAIL sb64_fault: got flt=%b rd=%b want 1/0", Resp_Fault, MemRead); end
    tick();
    issue(1'b0, 3'b100, 64'd63, 64'd0);
    checks++; if (MemRead !== 1'b1 || Mem_Addr !== 64'd56) begin errors++; $display("FAIL lbu63_read: got rd=%b ma=%h want 1/38", MemRead, Mem_Addr); end
    tick();
    checks++; if (Resp_Fault !== 1'b0 || Resp_Data !== 64'h5A) begin errors++; $display("FAIL lbu63_resp: got flt=%b d=%h want 0/5a", Resp_Fault, Resp_Data); end
    tick();
  endtask

  task automatic test_reset_rmw();
    int writes = 0;
    issue(1'b1, 3'b000, 64'd9, 64'hAA);
    checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL rst_rmw_rd: got %b want 1", MemRead); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (MemWrite) writes++;
    checks++; if (Req_Ready !== 1'b1 || Resp_Valid !== 1'b0) begin errors++; $display("FAIL rst_rmw_idle: got rdy=%b rv=%b want 1/0", Req_Ready, Resp_Valid); end
    tick();
    if (MemWrite) writes++;
    tick();
    if (MemWrite) writes++;
    checks++; if (writes != 0) begin errors++; $display("FAIL rst_rmw_nowrite: got %0d want 0", writes); end
    checks++; if (mem[1] !== 64'h8877_6655_BEEF_2211) begin errors++; $display("FAIL rst_rmw_mem: got %h want 88776655beef2211", mem[1]); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    Req_Valid = 1'b1; Req_Write = 1'b0; Req_Funct3 = 3'b000; Req_Addr = 64'd8; Req_Data = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 8) Req_Valid = 1'b0;
      if (Resp_Valid) pulses++;
      checks++; if (Req_Ready !== (i % 3 == 2) || Resp_Valid !== (i % 3 == 1)) begin errors++; $display("FAIL b2b_cycle%0d: got rdy=%b rv=%b want %b/%b", i, Req_Ready, Resp_Valid, (i % 3 == 2), (i % 3 == 1)); end
      if (i % 3 == 1) begin
        checks++; if (Resp_Data !== 64'h11) begin errors++; $display("FAIL b2b_data%0d: got %h want 11", i, Resp_Data); end
      end
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 64'd0;
    mem[1] = 64'h8877_6655_4433_2211;
    mem[7] = 64'h5A00_0000_0000_0000;
    reset = 1'b0; Req_Valid = 1'b0; Req_Write = 1'b0; Req_Funct3 = 3'b000;
    Req_Addr = '0; Req_Data = '0;
    #1;
    test_reset();
    test_load_byte();
    test_store_half();
    test_store_dword();
    test_misaligned_fault();
    test_reset_rmw();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 64, meaning the size in bytes of the attached data memory.
REQ-002 SHALL have clk  in  1  the single clock, rising edge.
REQ-003 SHALL have reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have Req_Valid  in  1  pipeline request present.
REQ-005 SHALL have Req_Ready  out  1  unit is idle and accepts a request.
REQ-006 SHALL have Req_Write  in  1  1 = store, 0 = load.
REQ-007 SHALL have Req_Funct3  in  3  000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-008 SHALL have Req_Addr  in  64  byte address of the access.
REQ-009 SHALL have Req_Data  in  64  store data, right-justified.
REQ-010 SHALL have Resp_Valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have Resp_Data  out  64  extended load result, 0 for stores.
REQ-012 SHALL have Resp_Misaligned  out  1  Req_Addr not aligned to the access size.
REQ-013 SHALL have Resp_Fault  out  1  access lies outside DEPTH_BYTES, or Req_Funct3 is 111.
REQ-014 SHALL have Mem_Addr  out  64, Write_Data  out  64, MemWrite  out  1, MemRead  out  1, Read_Data  in  64, driving the doubleword data memory.

Function
REQ-015 Req_Ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with Req_Valid=1 and Req_Ready=1, and all Req_* fields SHALL be latched then.
REQ-016 FSM states SHALL be IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-017 From IDLE, an accepted request SHALL go to RESP when faulted or misaligned, to LOAD for a load, to WRITE for a D store, and to RMW_RD for a B/H/W store.
REQ-018 LOAD->RESP, RMW_RD->WRITE, WRITE->RESP and RESP->IDLE transitions SHALL be unconditional.
REQ-019 Latency from accept to Resp_Valid SHALL be: fault or misaligned 1 cycle, load 2, D store 2, sub-word store 3.
REQ-020 Mem_Addr SHALL be {addr[63:3],3'b000} in LOAD, RMW_RD and WRITE, and 0 otherwise.
REQ-021 MemRead SHALL be 1 only in LOAD and RMW_RD; Read_Data SHALL be captured at the rising edge that leaves that state.
REQ-022 MemWrite SHALL be 1 only in WRITE, for exactly one cycle, so the memory commits on that cycle's falling edge.
REQ-023 The load result SHALL take byte lane addr[2:0] (size 1/2/4/8 bytes) from the captured doubleword, sign-extended for B/H/W/D and zero-extended for BU/HU/WU.
REQ-024 The sub-word store SHALL write back the captured doubleword with lanes addr[2:0]..addr[2:0]+size-1 replaced by the low bytes of Req_Data.
REQ-025 Misaligned SHALL mean addr[0]!=0 for H/HU, addr[1:0]!=0 for W/WU, and addr[2:0]!=0 for D.
REQ-026 Fault SHALL mean addr+size > DEPTH_BYTES, or Req_Funct3 = 111 (also 111 with Req_Write=1).
REQ-027 A faulted or misaligned request SHALL never assert MemRead or MemWrite; Fault SHALL take priority over Misaligned.
REQ-028 Resp_Data, Resp_Misaligned and Resp_Fault SHALL be valid only while Resp_Valid=1 and SHALL be 0 otherwise.
REQ-029 Req_Valid while Req_Ready=0 SHALL be ignored, with no queuing; a new request can be accepted no earlier than the cycle after RESP.

Reset
REQ-030 At a rising edge with reset=1, the state SHALL become IDLE and every output SHALL become 0 except Req_Ready=1.
REQ-031 Reset arriving in RMW_RD or LOAD SHALL abandon the access with no write.
REQ-032 Reset asserted at the edge entering WRITE SHALL cause no write; a falling edge that has already occurred in WRITE commits the write.
REQ-033 Reset SHALL take priority over a simultaneous Req_Valid.

Structure
REQ-034 Package lsu_pkg SHALL hold the funct3 encodings, the state encoding, and the size-from-funct3 function.
REQ-035 One combinational sub-module, lsu_lane_align, SHALL perform lane extraction, extension and store-merge; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-036 Verification SHALL cover these directed scenarios:
- Memory dword 0x8877665544332211 at addr 8; load B at addr 15 -> Resp_Data 0xFFFFFFFFFFFFFF88 at accept+2; load BU -> 0x88.
- Store H 0xBEEF to addr 10 over the same dword -> MemRead in cycle +1, MemWrite in cycle +2 with Write_Data 0x88776655BEEF2211, Resp_Valid at +3.
- Store D 0x0123456789ABCDEF to addr 16 -> no MemRead, single MemWrite, Resp_Valid at +2; load D at addr 16 returns the same value.
- Load W at addr 6 -> Resp_Misaligned=1 at +1, MemRead/MemWrite never asserted; load D at addr 60 -> Resp_Fault=1.
- Reset asserted in RMW_RD of a store B -> IDLE, Req_Ready=1, memory unchanged.
- Req_Valid held high back-to-back -> each response pulses once, and Req_Ready=0 from the edge after accept until the cycle after RESP.
